// File: rtl/traffic_seq.sv
// N-way traffic-light sequencer with demand skipping, rest-in-green and night flash.
// All state moves on the internal 1 s tick; lamp pins are registered and active-low.
module traffic_seq #(
    parameter int N_WAY    = 3,
    parameter int CLK_HZ   = 50000000,
    parameter int T_ALLRED = 5,
    parameter int T_PREP   = 2,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 2
) (
    input  logic                     clk50M,
    input  logic                     rst,
    input  logic [N_WAY-1:0]         req,
    input  logic                     flash_en,
    output logic [N_WAY-1:0]         green_n,
    output logic [N_WAY-1:0]         yellow_n,
    output logic [N_WAY-1:0]         red_n,
    output logic [$clog2(N_WAY)-1:0] cur_way,
    output logic                     tick
);

    localparam int CW = $clog2(N_WAY);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TM1 = (T_ALLRED > T_PREP) ? T_ALLRED : T_PREP;
    localparam int TM2 = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int SW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_ALLRED,
        S_PREP,
        S_GREEN,
        S_YELLOW,
        S_FLASH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic [CW-1:0]   way_q, way_d;
    logic            flash_q, flash_d;
    logic [N_WAY-1:0] red_n_q, red_n_d;
    logic [N_WAY-1:0] yel_n_q, yel_n_d;
    logic [N_WAY-1:0] grn_n_q, grn_n_d;

    logic            tick_w;
    logic            found;
    logic [CW-1:0]   next_way;
    logic            other_req;
    logic [N_WAY-1:0] oh;
    int              idx;

    always_comb begin
        tick_w  = 1'b0;
        presc_d = presc_q + 1'b1;
        if (presc_q == PW'(CLK_HZ - 1)) begin
            presc_d = '0;
            tick_w  = 1'b1;
        end
    end

    // Round-robin pick: starts after the last served way, ends on it.
    always_comb begin
        found    = 1'b0;
        next_way = way_q;
        idx      = 0;
        for (int i = 1; i <= N_WAY; i++) begin
            idx = (int'(way_q) + i) % N_WAY;
            if (!found && req[idx]) begin
                found    = 1'b1;
                next_way = CW'(idx);
            end
        end
    end

    always_comb begin
        other_req = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (CW'(i) != way_q && req[i]) begin
                other_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        way_d   = way_q;
        flash_d = flash_q;
        if (tick_w) begin
            if (state_q == S_FLASH) begin
                if (flash_en) begin
                    flash_d = ~flash_q;
                end else begin
                    state_d = S_ALLRED;
                    sec_d   = '0;
                    flash_d = 1'b0;
                end
            end else if (flash_en) begin
                state_d = S_FLASH;
                sec_d   = '0;
                flash_d = 1'b1;
            end else begin
                sec_d = sec_q + 1'b1;
                unique case (state_q)
                    S_ALLRED: begin
                        if (sec_q == SW'(T_ALLRED - 1)) begin
                            sec_d = '0;
                            if (found) begin
                                state_d = S_PREP;
                                way_d   = next_way;
                            end
                        end
                    end
                    S_PREP: begin
                        if (sec_q == SW'(T_PREP - 1)) begin
                            state_d = S_GREEN;
                            sec_d   = '0;
                        end
                    end
                    S_GREEN: begin
                        // Counter saturates while resting in green.
                        if (sec_q >= SW'(T_GREEN - 1)) begin
                            sec_d = sec_q;
                            if (other_req) begin
                                state_d = S_YELLOW;
                                sec_d   = '0;
                            end
                        end
                    end
                    S_YELLOW: begin
                        if (sec_q == SW'(T_YELLOW - 1)) begin
                            state_d = S_ALLRED;
                            sec_d   = '0;
                        end
                    end
                    default: begin
                        state_d = S_ALLRED;
                        sec_d   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        oh      = N_WAY'(1) << way_d;
        red_n_d = '0;
        yel_n_d = '1;
        grn_n_d = '1;
        unique case (state_d)
            S_ALLRED: begin
            end
            S_PREP: begin
                yel_n_d = ~oh;
            end
            S_GREEN: begin
                red_n_d = oh;
                grn_n_d = ~oh;
            end
            S_YELLOW: begin
                red_n_d = oh;
                yel_n_d = ~oh;
            end
            S_FLASH: begin
                red_n_d = '1;
                yel_n_d = flash_d ? '0 : '1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            state_q <= S_ALLRED;
            way_q   <= CW'(N_WAY - 1);
            flash_q <= 1'b0;
            red_n_q <= '0;
            yel_n_q <= '1;
            grn_n_q <= '1;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            state_q <= state_d;
            way_q   <= way_d;
            flash_q <= flash_d;
            red_n_q <= red_n_d;
            yel_n_q <= yel_n_d;
            grn_n_q <= grn_n_d;
        end
    end

    assign tick     = tick_w;
    assign cur_way  = way_q;
    assign red_n    = red_n_q;
    assign yellow_n = yel_n_q;
    assign green_n  = grn_n_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Directed bench for traffic_seq: expected lamp states per tick are queued
// from the phase schedule and compared one cycle after each tick.
module tb_traffic_seq;

    localparam int PH_AR   = 0;
    localparam int PH_PREP = 1;
    localparam int PH_GRN  = 2;
    localparam int PH_YEL  = 3;
    localparam int PH_FON  = 4;
    localparam int PH_FOFF = 5;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       flash_en = 1'b0;
    logic [2:0] green_n;
    logic [2:0] yellow_n;
    logic [2:0] red_n;
    logic [1:0] cur_way;
    logic       tick;

    typedef struct {
        string      tag;
        logic [8:0] lamps;
        logic [1:0] way;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    traffic_seq #(
        .N_WAY(3),
        .CLK_HZ(4),
        .T_ALLRED(5),
        .T_PREP(2),
        .T_GREEN(10),
        .T_YELLOW(2)
    ) dut (
        .clk50M(clk50M),
        .rst(rst),
        .req(req),
        .flash_en(flash_en),
        .green_n(green_n),
        .yellow_n(yellow_n),
        .red_n(red_n),
        .cur_way(cur_way),
        .tick(tick)
    );

    always #5 clk50M = ~clk50M;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [11:0] obs,
                         input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Lamp pattern {red_n, yellow_n, green_n} for a phase on way w.
    task automatic push_ph(input string tag, input int ph, input int w,
                           input int n);
        logic [2:0] oh;
        exp_t       e;
        oh = 3'b001 << w;
        case (ph)
            PH_PREP: e.lamps = {3'b000, ~oh, 3'b111};
            PH_GRN:  e.lamps = {oh, 3'b111, ~oh};
            PH_YEL:  e.lamps = {oh, ~oh, 3'b111};
            PH_FON:  e.lamps = {3'b111, 3'b000, 3'b111};
            PH_FOFF: e.lamps = {3'b111, 3'b111, 3'b111};
            default: e.lamps = {3'b000, 3'b111, 3'b111};
        endcase
        e.tag = tag;
        e.way = 2'(w);
        repeat (n) sb.push_back(e);
    endtask

    task automatic push_way(input string tag, input int w);
        push_ph(tag, PH_PREP, w, 2);
        push_ph(tag, PH_GRN, w, 10);
        push_ph(tag, PH_YEL, w, 2);
        push_ph(tag, PH_AR, w, 5);
    endtask

    task automatic run_all();
        exp_t e;
        int   k;
        while (sb.size() > 0) begin
            k = 0;
            while (!tick && k < 8) begin
                @(negedge clk50M);
                k++;
            end
            check("tick_wait", {11'd0, tick}, 12'd1);
            @(negedge clk50M);
            e = sb.pop_front();
            check(e.tag, {1'b0, red_n, yellow_n, green_n, cur_way},
                  {1'b0, e.lamps, e.way});
            check("tick_pulse", {11'd0, tick}, 12'd0);
        end
    endtask

    task automatic do_reset(input logic [2:0] r);
        rst = 1'b1;
        req = r;
        flash_en = 1'b0;
        @(negedge clk50M);
        @(negedge clk50M);
        rst = 1'b0;
    endtask

    initial begin
        // 1: full rotation with all ways requesting
        do_reset(3'b111);
        check("reset", {red_n, yellow_n, green_n, cur_way, tick},
              {3'b000, 3'b111, 3'b111, 2'd2, 1'b0});
        push_ph("rot_ar0", PH_AR, 2, 4);
        push_way("rot_w0", 0);
        push_way("rot_w1", 1);
        push_way("rot_w2", 2);
        push_way("rot_w0b", 0);
        run_all();

        // 2: way 1 never requests
        do_reset(3'b101);
        push_ph("skip_ar0", PH_AR, 2, 4);
        push_way("skip_w0", 0);
        push_way("skip_w2", 2);
        push_way("skip_w0b", 0);
        push_way("skip_w2b", 2);
        run_all();

        // 3: rest in green, off-tick pulse ignored, then real demand
        do_reset(3'b001);
        push_ph("rest_ar0", PH_AR, 2, 4);
        push_ph("rest_prep", PH_PREP, 0, 2);
        push_ph("rest_grn", PH_GRN, 0, 16);
        run_all();
        req = 3'b101;
        @(negedge clk50M);
        req = 3'b001;
        push_ph("rest_pulse", PH_GRN, 0, 2);
        run_all();
        req = 3'b101;
        push_ph("rest_yel", PH_YEL, 0, 2);
        push_ph("rest_ar", PH_AR, 0, 5);
        push_ph("rest_prep2", PH_PREP, 2, 2);
        push_ph("rest_grn2", PH_GRN, 2, 1);
        run_all();

        // 4: no demand at all
        do_reset(3'b000);
        push_ph("idle_ar", PH_AR, 2, 20);
        run_all();

        // 5: night flash entered from green
        do_reset(3'b111);
        push_ph("fl_ar0", PH_AR, 2, 4);
        push_ph("fl_prep", PH_PREP, 0, 2);
        push_ph("fl_grn", PH_GRN, 0, 3);
        run_all();
        flash_en = 1'b1;
        push_ph("fl_on", PH_FON, 0, 1);
        push_ph("fl_off", PH_FOFF, 0, 1);
        push_ph("fl_on", PH_FON, 0, 1);
        push_ph("fl_off", PH_FOFF, 0, 1);
        run_all();
        flash_en = 1'b0;
        push_ph("fl_ar", PH_AR, 0, 5);
        push_ph("fl_prep1", PH_PREP, 1, 1);
        run_all();

        // 6: reset pulse in the middle of green
        do_reset(3'b111);
        push_ph("mr_ar0", PH_AR, 2, 4);
        push_ph("mr_prep", PH_PREP, 0, 2);
        push_ph("mr_grn", PH_GRN, 0, 3);
        run_all();
        @(negedge clk50M);
        rst = 1'b1;
        @(negedge clk50M);
        check("midrst", {red_n, yellow_n, green_n, cur_way, tick},
              {3'b000, 3'b111, 3'b111, 2'd2, 1'b0});
        rst = 1'b0;
        push_ph("mr_ar", PH_AR, 2, 4);
        push_ph("mr_prep0", PH_PREP, 0, 2);
        push_ph("mr_grn0", PH_GRN, 0, 1);
        run_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
